// File: rtl/lgn_test_sequencer.sv
// Test sequencer for the LGN MNIST core: streams stored images from a pattern ROM,
// captures each prediction, checks it against the expected label and keeps run statistics.
module lgn_test_sequencer #(
  parameter int IMAGE_COUNT     = 450,
  parameter int BYTES_PER_IMAGE = 32,
  parameter int REPEATS         = 2,
  parameter int CAPTURE_DELAY   = 2,
  parameter int DWELL_CYCLES    = 1200000,
  localparam int IW = $clog2(IMAGE_COUNT),
  localparam int BW = $clog2(BYTES_PER_IMAGE),
  localparam int CW = $clog2(IMAGE_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_on_fail,
  output logic [IW+BW-1:0] mem_addr,
  input  logic [7:0]       mem_data,
  output logic [7:0]       core_data,
  input  logic [3:0]       core_index,
  input  logic [7:0]       core_value,
  output logic [3:0]       result_index,
  output logic [7:0]       result_value,
  output logic             result_valid,
  output logic             busy,
  output logic             done,
  output logic             failure,
  output logic [CW-1:0]    pass_count,
  output logic [CW-1:0]    fail_count,
  output logic [IW-1:0]    first_fail_image
);

  localparam int PW  = $clog2(REPEATS + 1);
  localparam int DLW = (CAPTURE_DELAY > 1) ? $clog2(CAPTURE_DELAY) : 1;
  localparam int DWW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_STREAM = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DWELL  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [IW-1:0]   img_r;
  logic [BW-1:0]   byte_r;
  logic [PW-1:0]   pass_r;
  logic [3:0]      label_r;
  logic [DLW-1:0]  delay_r;
  logic [DWW-1:0]  dwell_r;
  logic            stream_d_r;
  logic [3:0]      result_index_r;
  logic [7:0]      result_value_r;
  logic            result_valid_r;
  logic            busy_r;
  logic            done_r;
  logic            failure_r;
  logic [CW-1:0]   pass_count_r;
  logic [CW-1:0]   fail_count_r;
  logic [IW-1:0]   first_fail_r;

  logic byte_last_s;
  logic pass_last_s;
  logic delay_last_s;
  logic dwell_last_s;
  logic img_last_s;
  logic match_s;

  assign byte_last_s  = (byte_r == BW'(BYTES_PER_IMAGE - 1));
  assign pass_last_s  = (pass_r == PW'(REPEATS - 1));
  assign delay_last_s = (delay_r == DLW'(CAPTURE_DELAY - 1));
  assign dwell_last_s = (dwell_r == DWW'(DWELL_CYCLES - 1));
  assign img_last_s   = (img_r == IW'(IMAGE_COUNT - 1));
  assign match_s      = (core_index == label_r);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) state_nx_s = ST_STREAM;
        else       state_nx_s = state_r;
      end
      ST_STREAM: begin
        if (byte_last_s && pass_last_s) state_nx_s = ST_SETTLE;
        else                            state_nx_s = ST_STREAM;
      end
      ST_SETTLE: begin
        if (delay_last_s) state_nx_s = ST_CHECK;
        else              state_nx_s = ST_SETTLE;
      end
      ST_CHECK: begin
        if (!match_s && halt_on_fail) state_nx_s = ST_DONE;
        else                          state_nx_s = ST_DWELL;
      end
      ST_DWELL: begin
        if (!dwell_last_s)   state_nx_s = ST_DWELL;
        else if (img_last_s) state_nx_s = ST_DONE;
        else                 state_nx_s = ST_STREAM;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Sequencing counters, result capture and run statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_r          <= '0;
      byte_r         <= '0;
      pass_r         <= '0;
      label_r        <= 4'd0;
      delay_r        <= '0;
      dwell_r        <= '0;
      stream_d_r     <= 1'b0;
      result_index_r <= 4'd0;
      result_value_r <= 8'd0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      failure_r      <= 1'b0;
      pass_count_r   <= '0;
      fail_count_r   <= '0;
      first_fail_r   <= '0;
    end else begin
      result_valid_r <= 1'b0;
      stream_d_r     <= (state_r == ST_STREAM);
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            img_r        <= '0;
            byte_r       <= '0;
            pass_r       <= '0;
            label_r      <= 4'd0;
            pass_count_r <= '0;
            fail_count_r <= '0;
            failure_r    <= 1'b0;
            first_fail_r <= '0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
          end
        end
        ST_STREAM: begin
          // byte counter wraps naturally because BYTES_PER_IMAGE is a power of two
          byte_r  <= byte_r + BW'(1);
          delay_r <= '0;
          if (byte_last_s) pass_r <= pass_r + PW'(1);
        end
        ST_SETTLE: begin
          delay_r <= delay_r + DLW'(1);
          dwell_r <= '0;
        end
        ST_CHECK: begin
          result_index_r <= core_index;
          result_value_r <= core_value;
          result_valid_r <= 1'b1;
          if (match_s) begin
            pass_count_r <= pass_count_r + CW'(1);
          end else begin
            fail_count_r <= fail_count_r + CW'(1);
            failure_r    <= 1'b1;
            if (!failure_r) first_fail_r <= img_r;
            if (halt_on_fail) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        ST_DWELL: begin
          dwell_r <= dwell_r + DWW'(1);
          if (dwell_last_s) begin
            if (img_last_s) begin
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              img_r   <= img_r + IW'(1);
              label_r <= (label_r == 4'd9) ? 4'd0 : label_r + 4'd1;
              byte_r  <= '0;
              pass_r  <= '0;
            end
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr         = {img_r, byte_r};
  assign core_data        = stream_d_r ? mem_data : 8'h00;
  assign result_index     = result_index_r;
  assign result_value     = result_value_r;
  assign result_valid     = result_valid_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign failure          = failure_r;
  assign pass_count       = pass_count_r;
  assign fail_count       = fail_count_r;
  assign first_fail_image = first_fail_r;

endmodule

// File: tb/tb_lgn_test_sequencer.sv
// Directed bench for lgn_test_sequencer with a synchronous ROM model and a scripted core model.
module tb_lgn_test_sequencer;

  localparam int IC = 4;
  localparam int AW = 7;   // 2 image bits + 5 byte bits

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          halt_on_fail;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic [7:0]    core_data;
  logic [3:0]    core_index;
  logic [7:0]    core_value;
  logic [3:0]    result_index;
  logic [7:0]    result_value;
  logic          result_valid;
  logic          busy;
  logic          done;
  logic          failure;
  logic [2:0]    pass_count;
  logic [2:0]    fail_count;
  logic [1:0]    first_fail_image;

  logic [7:0] rom [128];
  int         checks;
  int         failures;
  int         cyc;
  int         ovr_img;
  logic [3:0] ovr_val;

  lgn_test_sequencer #(.IMAGE_COUNT(IC), .DWELL_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_on_fail(halt_on_fail),
    .mem_addr(mem_addr), .mem_data(mem_data), .core_data(core_data),
    .core_index(core_index), .core_value(core_value),
    .result_index(result_index), .result_value(result_value), .result_valid(result_valid),
    .busy(busy), .done(done), .failure(failure), .pass_count(pass_count),
    .fail_count(fail_count), .first_fail_image(first_fail_image)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[mem_addr];

  // Core model: predicts the image number, except for one scripted wrong answer
  always_comb begin
    core_value = {4'h5, 2'b00, mem_addr[6:5]};
    if (ovr_img == int'(mem_addr[6:5])) core_index = ovr_val;
    else                                core_index = {2'b00, mem_addr[6:5]};
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_run(input logic halt, input int oimg, input logic [3:0] oval);
    halt_on_fail = halt;
    ovr_img      = oimg;
    ovr_val      = oval;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    cyc          = 0;
  endtask

  // Runs until done, checking every result pulse; returns pulse count and highest image addressed
  task automatic watch(input int budget, output int n_valid, output int max_img);
    int prev;
    int n;
    n = 0;
    prev = 0;
    max_img = 0;
    while (!done && cyc < budget) begin
      tick();
      if (int'(mem_addr[6:5]) > max_img) max_img = int'(mem_addr[6:5]);
      if (result_valid) begin
        check_eq("valid_gap", cyc - prev, (n == 0) ? 67 : 70);
        check_eq("res_index", result_index, (n == ovr_img) ? ovr_val : 4'(n));
        check_eq("res_value", result_value, 8'h50 + 8'(n));
        prev = cyc;
        n++;
      end
    end
    check_eq("done_in_budget", done, 1'b1);
    n_valid = n;
  endtask

  initial begin
    int nv;
    int mi;
    checks = 0;
    failures = 0;
    cyc = 0;
    for (int i = 0; i < 128; i++) rom[i] = 8'(i * 37 + 11);
    rst_n = 1'b0;
    start = 1'b0;
    halt_on_fail = 1'b0;
    ovr_img = -1;
    ovr_val = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Reset then idle
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_failure", failure, 1'b0);
    check_eq("rst_valid", result_valid, 1'b0);
    check_eq("rst_index", result_index, 4'd0);
    check_eq("rst_value", result_value, 8'd0);
    check_eq("rst_pass", pass_count, 3'd0);
    check_eq("rst_fail", fail_count, 3'd0);
    check_eq("rst_first", first_fail_image, 2'd0);
    check_eq("rst_addr", mem_addr, 7'd0);
    check_eq("rst_core_data", core_data, 8'd0);

    // Alignment, then carry on as the all-pass run
    start_run(1'b0, -1, 4'd0);
    check_eq("busy_after_start", busy, 1'b1);
    check_eq("core_data_gated", core_data, 8'd0);
    for (int k = 0; k < 64; k++) begin
      check_eq("stream_addr", mem_addr, 7'(k % 32));
      tick();
      check_eq("core_data_align", core_data, rom[k % 32]);
    end
    watch(400, nv, mi);
    check_eq("allpass_pulses", nv, 4);
    check_eq("allpass_pass", pass_count, 3'd4);
    check_eq("allpass_fail", fail_count, 3'd0);
    check_eq("allpass_failure", failure, 1'b0);
    check_eq("allpass_busy", busy, 1'b0);
    check_eq("allpass_first", first_fail_image, 2'd0);

    // Single fail, no halt
    start_run(1'b0, 2, 4'd7);
    check_eq("restart_done_clr", done, 1'b0);
    watch(400, nv, mi);
    check_eq("nohalt_pulses", nv, 4);
    check_eq("nohalt_pass", pass_count, 3'd3);
    check_eq("nohalt_fail", fail_count, 3'd1);
    check_eq("nohalt_first", first_fail_image, 2'd2);
    check_eq("nohalt_failure", failure, 1'b1);

    // Halt on fail
    start_run(1'b1, 1, 4'd7);
    watch(400, nv, mi);
    check_eq("halt_pulses", nv, 2);
    check_eq("halt_index", result_index, 4'd7);
    check_eq("halt_pass", pass_count, 3'd1);
    check_eq("halt_fail", fail_count, 3'd1);
    check_eq("halt_first", first_fail_image, 2'd1);
    check_eq("halt_max_img", mi, 1);
    check_eq("halt_busy", busy, 1'b0);
    repeat (10) tick();
    check_eq("halt_addr_img", mem_addr[6:5], 2'd1);
    check_eq("halt_done_held", done, 1'b1);

    // Reset mid-run during image 2 streaming
    start_run(1'b0, -1, 4'd0);
    while (mem_addr[6:5] != 2'd2 && cyc < 300) tick();
    check_eq("reach_img2", mem_addr[6:5], 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_busy", busy, 1'b0);
    check_eq("mid_pass", pass_count, 3'd0);
    check_eq("mid_index", result_index, 4'd0);
    check_eq("mid_value", result_value, 8'd0);
    check_eq("mid_addr", mem_addr, 7'd0);
    check_eq("mid_core_data", core_data, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    start_run(1'b0, -1, 4'd0);
    check_eq("rerun_addr", mem_addr, 7'd0);
    watch(400, nv, mi);
    check_eq("rerun_pulses", nv, 4);
    check_eq("rerun_pass", pass_count, 3'd4);
    check_eq("rerun_fail", fail_count, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
